// File: rtl/ds_sinc3_decimator.sv
// Third-order sinc (CIC) decimator: 1-bit delta-sigma stream in, W-bit PCM out.
// Optional DS_DEC_SIGNED_OUT_EN selects a two's complement, midscale-zero output.
module ds_sinc3_decimator #(
  parameter  int OSR_LOG2 = 6,
  localparam int W        = 3*OSR_LOG2 + 1
) (
  input  logic         CLK,
  input  logic         reset_,
  input  logic         din,
  input  logic         din_en,
  output logic [W-1:0] dout,
  output logic         dout_valid
);

  logic [W-1:0]        i1, i2, i3;
  logic [W-1:0]        i3_prev, c1_prev, c2_prev;
  logic [OSR_LOG2-1:0] cnt;
  logic [1:0]          settle;

  logic [W-1:0] i3_next;
  logic [W-1:0] c1, c2, c3;
  logic [W-1:0] word;
  logic         frame_end;

  // Combs run on the post-edge I3 so a frame's snapshot covers all its samples.
  assign i3_next   = i3 + i2;
  assign c1        = i3_next - i3_prev;
  assign c2        = c1 - c1_prev;
  assign c3        = c2 - c2_prev;
  assign frame_end = din_en && (cnt == '1);

`ifdef DS_DEC_SIGNED_OUT_EN
  localparam logic [W-1:0] HALF = {2'b01, {(W-2){1'b0}}};
  assign word = c3 - HALF;
`else
  assign word = c3;
`endif

  always_ff @(posedge CLK or negedge reset_) begin
    if (!reset_) begin
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      i3_prev    <= '0;
      c1_prev    <= '0;
      c2_prev    <= '0;
      cnt        <= '0;
      settle     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (din_en) begin
        i1  <= i1 + W'(din);
        i2  <= i2 + i1;
        i3  <= i3_next;
        cnt <= cnt + 1'b1;
      end
      if (frame_end) begin
        i3_prev <= i3_next;
        c1_prev <= c1;
        c2_prev <= c2;
        // The first two frames only prime the comb delays.
        if (settle == 2'd2) begin
          dout       <= word;
          dout_valid <= 1'b1;
        end else begin
          settle <= settle + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ds_sinc3_decimator.sv
// Bench for ds_sinc3_decimator: closed-form CIC model plus literal word checks.
// Covers OSR=4 patterns, strobe gaps, mid-frame reset and OSR=64 wrap.
`timescale 1ns/1ps
module tb_ds_sinc3_decimator;

  localparam int R  = 4;
  localparam int W  = 7;
  localparam int W6 = 19;
`ifdef DS_DEC_SIGNED_OUT_EN
  localparam longint OFF    = 32;
  localparam logic [6:0] WD_ONES  = 7'd32;
  localparam logic [6:0] WD_ZERO  = 7'd96;
  localparam logic [6:0] WD_ALT   = 7'd0;
  localparam logic [18:0] WD6_ONES = 19'd131072;
`else
  localparam longint OFF    = 0;
  localparam logic [6:0] WD_ONES  = 7'd64;
  localparam logic [6:0] WD_ZERO  = 7'd0;
  localparam logic [6:0] WD_ALT   = 7'd32;
  localparam logic [18:0] WD6_ONES = 19'd262144;
`endif

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         reset_ = 1'b0;
  logic         din = 1'b0;
  logic         din_en = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;

  logic          reset6_ = 1'b0;
  logic          din6 = 1'b0;
  logic          din_en6 = 1'b0;
  logic [W6-1:0] dout6;
  logic          dout_valid6;

  ds_sinc3_decimator #(.OSR_LOG2(2)) u_dut (
    .CLK(CLK), .reset_(reset_), .din(din), .din_en(din_en),
    .dout(dout), .dout_valid(dout_valid)
  );

  ds_sinc3_decimator #(.OSR_LOG2(6)) u_dut6 (
    .CLK(CLK), .reset_(reset6_), .din(din6), .din_en(din_en6),
    .dout(dout6), .dout_valid(dout_valid6)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: I3 after n samples is sum x[j]*C(n-1-j,2); a word is the
  // third difference of the per-frame I3 values, reduced mod 2**W.
  longint hist[$];
  longint i3f[$];
  int     nacc = 0;
  bit     exp_v = 1'b0;
  longint exp_d = 0;
  bit     chk_en = 1'b0;

  function automatic longint i3_of(input int n);
    longint s = 0;
    for (int j = 0; j < n; j++) begin
      longint k = n - 1 - j;
      s += hist[j] * ((k * (k - 1)) / 2);
    end
    return s;
  endfunction

  function automatic longint fr(input int k);
    return (k >= 0) ? i3f[k] : 0;
  endfunction

  function automatic longint frame_word();
    int f = i3f.size() - 1;
    longint c = fr(f) - 3*fr(f-1) + 3*fr(f-2) - fr(f-3);
    return (c - OFF) & 64'd127;
  endfunction

  initial begin
    forever begin
      @(posedge CLK or negedge reset_);
      if (!reset_) begin
        hist.delete();
        i3f.delete();
        nacc  = 0;
        exp_v = 1'b0;
        exp_d = 0;
      end else begin
        exp_v = 1'b0;
        if (din_en) begin
          hist.push_back(longint'(din));
          nacc++;
          if (nacc % R == 0) begin
            i3f.push_back(i3_of(nacc));
            if (i3f.size() >= 3) begin
              exp_v = 1'b1;
              exp_d = frame_word();
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        check("model valid", dout_valid, exp_v);
        check("model dout", dout, exp_d);
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    #3 reset_ = 1'b0;
    #1;
    check("reset dout", dout, 0);
    check("reset valid", dout_valid, 0);
    @(negedge CLK);
    @(negedge CLK);
    reset_ = 1'b1;
  endtask

  // pat: 0 zeros, 1 ones, 2 alternating, 3 random (model only)
  task automatic run_pat(input string nm, input int pat, input int duty,
                         input int ncyc, input logic [6:0] word,
                         input int first_c);
    int nv  = 0;
    int acc = 0;
    bit ph  = 1'($urandom_range(1));
    for (int c = 1; c <= ncyc; c++) begin
      din_en = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
      case (pat)
        0:       din = 1'b0;
        1:       din = 1'b1;
        2:       din = ph;
        default: din = 1'($urandom_range(1));
      endcase
      if (din_en) begin
        acc++;
        ph = ~ph;
      end
      @(posedge CLK);
      @(negedge CLK);
      if (dout_valid) begin
        nv++;
        if (pat < 3) check(nm, dout, word);
        if (nv == 1 && first_c > 0) check({nm, " first"}, c + 1, first_c);
      end
    end
    din_en = 1'b0;
    check({nm, " count"}, nv, (acc / R > 2) ? acc / R - 2 : 0);
  endtask

  int n6 = 0;

  initial begin
    #1 chk_en = 1'b1;
    check("init dout", dout, 0);
    check("init valid", dout_valid, 0);
    @(negedge CLK);
    reset_ = 1'b1;

    run_pat("ones", 1, 100, 40, WD_ONES, 13);
    do_reset();
    run_pat("zeros", 0, 100, 40, WD_ZERO, 13);
    do_reset();
    run_pat("alt", 2, 100, 40, WD_ALT, 13);
    do_reset();
    run_pat("alt2", 2, 100, 41, WD_ALT, 13);
    do_reset();
    run_pat("ones gap", 1, 40, 200, WD_ONES, 0);
    do_reset();
    run_pat("random", 3, 60, 400, 7'd0, 0);
    do_reset();
    run_pat("random full", 3, 100, 200, 7'd0, 0);

    do_reset();
    run_pat("ones pre", 1, 100, 30, WD_ONES, 13);
    do_reset();
    run_pat("ones post", 1, 100, 40, WD_ONES, 13);

    check("osr64 reset dout", dout6, 0);
    check("osr64 reset valid", dout_valid6, 0);
    @(negedge CLK);
    reset6_ = 1'b1;
    din6    = 1'b1;
    din_en6 = 1'b1;
    for (int c = 1; c <= 10000; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (dout_valid6) begin
        n6++;
        check("osr64 word", dout6, WD6_ONES);
        if (n6 == 1) check("osr64 first", c + 1, 193);
      end
    end
    din_en6 = 1'b0;
    @(negedge CLK);
    check("osr64 count", n6, 154);
    check("osr64 hold", dout6, WD6_ONES);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
